// File: rtl/md_pkg.sv
// Shared op codes, FSM encoding and default latencies for the E-stage multiply/divide unit.
// Build option: define MD_MADD_EN to make MD_MADD/MD_MSUB long accumulate ops.
package md_pkg;

    localparam logic [3:0] MD_MULT  = 4'd0;
    localparam logic [3:0] MD_MULTU = 4'd1;
    localparam logic [3:0] MD_DIV   = 4'd2;
    localparam logic [3:0] MD_DIVU  = 4'd3;
    localparam logic [3:0] MD_MTHI  = 4'd4;
    localparam logic [3:0] MD_MTLO  = 4'd5;
    localparam logic [3:0] MD_MADD  = 4'd6;
    localparam logic [3:0] MD_MSUB  = 4'd7;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;
    localparam int CNT_W_DEF    = 4;

    // Ops that occupy the unit for a fixed latency; madd/msub only when built in.
    function automatic logic is_long_op(input logic [3:0] op);
        logic r;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
`ifdef MD_MADD_EN
            MD_MADD, MD_MSUB: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit {HI,LO} result for a long MD op from the operands and current HI/LO.
// Build option: MD_MADD_EN enables the madd/msub accumulate results.
module md_calc
    import md_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [63:0] res_o
);

    logic [63:0] prod_s_s;
    logic [63:0] prod_u_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] q_mag_s;
    logic [31:0] r_mag_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

    // Signed ops go through magnitudes so 0x80000000 / -1 wraps instead of trapping.
    always_comb begin
        prod_s_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
        prod_u_s = {32'd0, a_i} * {32'd0, b_i};
        a_mag_s  = a_i[31] ? (32'd0 - a_i) : a_i;
        b_mag_s  = b_i[31] ? (32'd0 - b_i) : b_i;
        if (b_i != 32'd0) begin
            q_mag_s = a_mag_s / b_mag_s;
            r_mag_s = a_mag_s % b_mag_s;
        end else begin
            q_mag_s = 32'd0;
            r_mag_s = 32'd0;
        end
        quot_s = (a_i[31] ^ b_i[31]) ? (32'd0 - q_mag_s) : q_mag_s;
        rem_s  = a_i[31] ? (32'd0 - r_mag_s) : r_mag_s;
    end

    // Select the committed value; a zero divisor leaves HI/LO as they were.
    always_comb begin
        res_o = {hi_i, lo_i};
        case (op_i)
            MD_MULT:  res_o = prod_s_s;
            MD_MULTU: res_o = prod_u_s;
            MD_DIV:   res_o = (b_i == 32'd0) ? {hi_i, lo_i} : {rem_s, quot_s};
            MD_DIVU:  res_o = (b_i == 32'd0) ? {hi_i, lo_i} : {a_i % b_i, a_i / b_i};
`ifdef MD_MADD_EN
            MD_MADD:  res_o = {hi_i, lo_i} + prod_s_s;
            MD_MSUB:  res_o = {hi_i, lo_i} - prod_s_s;
`endif
            default:  res_o = {hi_i, lo_i};
        endcase
    end

endmodule

// File: rtl/md_unit_ctrl.sv
// E-stage multiply/divide sequencer: fixed-latency FSM, HI/LO ownership, D-stage stall.
// Build option: MD_MADD_EN adds madd/msub as long ops.
module md_unit_ctrl
    import md_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        md_inst_D,
    output logic        BUSY,
    output logic        stall_D,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        done
);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [63:0]      hold_q, hold_d;
    logic             done_q, done_d;
    logic             long_op_s;
    logic [63:0]      calc_res_s;

    assign long_op_s = is_long_op(md_op);

    // HI/LO cannot change while RUN, so the issue-time value equals the commit-time value.
    md_calc u_calc (
        .op_i  (md_op),
        .a_i   (A),
        .b_i   (B),
        .hi_i  (hi_q),
        .lo_i  (lo_q),
        .res_o (calc_res_s)
    );

    // Next-state: issue, count down, commit on the last busy cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && long_op_s) begin
                    state_d = ST_RUN;
                    cnt_d   = is_div_op(md_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                    hold_d  = calc_res_s;
                end else if (start && (md_op == MD_MTHI)) begin
                    hi_d = A;
                end else if (start && (md_op == MD_MTLO)) begin
                    lo_d = A;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d      = ST_IDLE;
                    {hi_d, lo_d} = hold_q;
                    done_d       = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset; reset discards any op in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            hold_q  <= 64'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
        end
    end

    assign BUSY    = (state_q == ST_RUN);
    assign stall_D = md_inst_D & (BUSY | (start & long_op_s));
    assign HI      = hi_q;
    assign LO      = lo_q;
    assign done    = done_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: directed scenarios then random ops vs a behavioural model.
module tb_md_unit_ctrl;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  md_op = 4'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        md_inst_D = 1'b0;
    logic        BUSY;
    logic        stall_D;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        done;

    md_unit_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
        .md_inst_D(md_inst_D), .BUSY(BUSY), .stall_D(stall_D), .HI(HI), .LO(LO), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int done_seen = 0;

    bit [31:0] m_hi = 32'd0;
    bit [31:0] m_lo = 32'd0;
    bit [63:0] m_pend = 64'd0;
    int        m_busy_left = 0;
    bit        m_done = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_is_long(input bit [3:0] op);
`ifdef MD_MADD_EN
        return op <= 4'd3 || op == MD_MADD || op == MD_MSUB;
`else
        return op <= 4'd3;
`endif
    endfunction

    // Reference result computed with 64-bit integer arithmetic.
    function automatic bit [63:0] m_result(input bit [3:0] op, input bit [31:0] a, input bit [31:0] b,
                                           input bit [31:0] hi, input bit [31:0] lo);
        longint          sa = longint'(signed'(a));
        longint          sb = longint'(signed'(b));
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint          q;
        longint          r;
        bit [63:0]       acc = {hi, lo};
        if (op == MD_MULT) return 64'(sa * sb);
        if (op == MD_MULTU) return 64'(ua * ub);
        if (op == MD_DIV || op == MD_DIVU) begin
            if (b == 32'd0) return acc;
            if (op == MD_DIV) begin
                q = sa / sb;
                r = sa % sb;
            end else begin
                q = longint'(ua / ub);
                r = longint'(ua % ub);
            end
            return {32'(r), 32'(q)};
        end
        if (op == MD_MADD) return acc + 64'(sa * sb);
        if (op == MD_MSUB) return acc - 64'(sa * sb);
        return acc;
    endfunction

    // One clock cycle: check outputs, drive inputs, check stall, advance the model across the edge.
    task automatic step(input bit rst, input bit st, input bit [3:0] op, input bit [31:0] a,
                        input bit [31:0] b, input bit dinst);
        bit lop;
        lop = m_is_long(op);
        @(negedge clk);
        check_eq("busy", BUSY, m_busy_left > 0);
        check_eq("hi", HI, m_hi);
        check_eq("lo", LO, m_lo);
        check_eq("done", done, m_done);
        if (done === 1'b1) done_seen++;
        reset = rst; start = st; md_op = op; A = a; B = b; md_inst_D = dinst;
        #1;
        check_eq("stall", stall_D, dinst && ((m_busy_left > 0) || (st && lop)));
        if (rst) begin
            m_hi = 32'd0; m_lo = 32'd0; m_busy_left = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_busy_left == 0) begin
                    {m_hi, m_lo} = m_pend;
                    m_done = 1'b1;
                end
            end else if (st) begin
                if (lop) begin
                    m_pend = m_result(op, a, b, m_hi, m_lo);
                    m_busy_left = (op == MD_DIV || op == MD_DIVU) ? 10 : 5;
                end else if (op == MD_MTHI) begin
                    m_hi = a;
                end else if (op == MD_MTLO) begin
                    m_lo = a;
                end
            end
        end
    endtask

    task automatic idle(input int n, input bit dinst);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, dinst);
    endtask

    function automatic bit [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    int d0;

    initial begin
        step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        idle(1, 1'b1);
        check_eq("rst_busy", BUSY, 1'b0);
        check_eq("rst_hilo", {HI, LO}, 64'd0);

        // mult -2 * 3, stall held through issue and every busy cycle
        done_seen = 0;
        step(1'b0, 1'b1, MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
        idle(7, 1'b1);
        check_eq("t1_hi", HI, 32'hFFFF_FFFF);
        check_eq("t1_lo", LO, 32'hFFFF_FFFA);
        check_eq("t1_done_cnt", done_seen, 1);

        step(1'b0, 1'b1, MD_DIVU, 32'd100, 32'd7, 1'b0);
        idle(11, 1'b0);
        check_eq("t2_divu", {HI, LO}, {32'd2, 32'd14});
        step(1'b0, 1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(11, 1'b0);
        check_eq("t2_div", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        step(1'b0, 1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(11, 1'b0);
        check_eq("t2_ovf", {HI, LO}, {32'd0, 32'h8000_0000});

        step(1'b0, 1'b1, MD_MTLO, 32'h1234, 32'd0, 1'b0);
        step(1'b0, 1'b1, MD_DIV, 32'd55, 32'd0, 1'b0);
        idle(11, 1'b0);
        check_eq("t3_lo", LO, 32'h1234);

        // reset at cnt=3 of a divide drops the op
        step(1'b0, 1'b1, MD_DIV, 32'd99, 32'd4, 1'b0);
        idle(7, 1'b0);
        d0 = done_seen;
        step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        idle(4, 1'b0);
        check_eq("t5_busy", BUSY, 1'b0);
        check_eq("t5_hilo", {HI, LO}, 64'd0);
        check_eq("t5_nodone", done_seen, d0);
        step(1'b1, 1'b1, MD_MULT, 32'd7, 32'd7, 1'b0);
        idle(2, 1'b0);
        check_eq("t5_rst_start", BUSY, 1'b0);

        step(1'b0, 1'b1, MD_MTLO, 32'd5, 32'd0, 1'b0);
        step(1'b0, 1'b1, MD_MADD, 32'd2, 32'd3, 1'b0);
        idle(7, 1'b0);
`ifdef MD_MADD_EN
        check_eq("t6_madd", LO, 32'd11);
`else
        check_eq("t6_madd", LO, 32'd5);
`endif

        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 9)),
                 pick_val(), pick_val(), $urandom_range(0, 1) == 1);
        end
        idle(12, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
